// File: rtl/add_pkg.sv
// add_pkg: shared program-counter constants for the add block
package add_pkg;
  localparam int PC_WIDTH = 32;
  localparam int PC_INC = 4;
endpackage

// File: rtl/add_core.sv
// add_core: combinational program-counter incrementer with carry-out
module add_core #(
  parameter int WIDTH = 32,
  parameter int INC = 4
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  assign {carry_o, sum_o} = {1'b0, pc_i} + (WIDTH+1)'(INC);
endmodule

// File: rtl/add.sv
// add: program-counter incrementer with enabled capture of sum, carry and misalignment
module add
  import add_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int INC = PC_INC
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             cap_en_i,
  output logic [WIDTH-1:0] pc_four_o,
  output logic [WIDTH-1:0] pc_four_q_o,
  output logic             wrap_q_o,
  output logic             misalign_q_o
);
  logic carry;
  add_core #(.WIDTH(WIDTH), .INC(INC)) u_core (
    .pc_i   (pc_i),
    .sum_o  (pc_four_o),
    .carry_o(carry)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_four_q_o  <= '0;
      wrap_q_o     <= 1'b0;
      misalign_q_o <= 1'b0;
    end else if (cap_en_i) begin
      pc_four_q_o  <= pc_four_o;
      wrap_q_o     <= carry;
      misalign_q_o <= |pc_i[1:0];
    end
  end
endmodule

// File: tb/tb_add.sv
// tb_add: directed and randomized checks of add against a plain-arithmetic model
module tb_add;
  logic        clk = 1'b0;
  logic        rst_ni, cap_en_i;
  logic [31:0] pc_i, pc_four_o, pc_four_q_o;
  logic        wrap_q_o, misalign_q_o;
  bit          run = 1'b0;
  int          total = 0, bad = 0;
  logic [31:0] m_q;
  logic        m_w, m_m;

  add dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .pc_i        (pc_i),
    .cap_en_i    (cap_en_i),
    .pc_four_o   (pc_four_o),
    .pc_four_q_o (pc_four_q_o),
    .wrap_q_o    (wrap_q_o),
    .misalign_q_o(misalign_q_o)
  );

  initial begin
    wait (run);
    forever #5 clk = ~clk;
  end

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, o, e);
    end
  endtask

  function automatic logic [31:0] exp_sum(input logic [31:0] p);
    longint s = longint'(p) + 64'd4;
    return s[31:0];
  endfunction

  function automatic logic exp_wrap(input logic [31:0] p);
    return (longint'(p) + 64'd4) >= 64'h1_0000_0000;
  endfunction

  task automatic step(input logic [31:0] p, input logic en, input logic r);
    pc_i = p;
    cap_en_i = en;
    rst_ni = r;
    #1;
    chk32("comb_sum", pc_four_o, exp_sum(p));
    @(posedge clk);
    if (!r) begin
      m_q = 32'd0;
      m_w = 1'b0;
      m_m = 1'b0;
    end else if (en) begin
      m_q = exp_sum(p);
      m_w = exp_wrap(p);
      m_m = (p % 4) != 0;
    end
    #1;
    chk32("q_sum", pc_four_q_o, m_q);
    chk1("q_wrap", wrap_q_o, m_w);
    chk1("q_misalign", misalign_q_o, m_m);
  endtask

  initial begin
    pc_i = 32'hF00FA76E;
    cap_en_i = 1'b0;
    #1;
    chk32("idle_clk_sum", pc_four_o, 32'hF00FA772);
    pc_i = 32'h0;
    #1;
    chk32("zero_sum", pc_four_o, 32'h4);
    run = 1'b1;
    step(32'h1234_5679, 1'b1, 1'b0);
    chk32("reset_q", pc_four_q_o, 32'h0);
    step(32'hFFFF_FFFC, 1'b1, 1'b1);
    chk32("wrap_comb", pc_four_o, 32'h0);
    chk32("wrap_q", pc_four_q_o, 32'h0);
    chk1("wrap_flag", wrap_q_o, 1'b1);
    step(32'h0000_0102, 1'b1, 1'b1);
    chk32("mis_comb", pc_four_o, 32'h106);
    chk1("mis_flag", misalign_q_o, 1'b1);
    chk1("mis_nowrap", wrap_q_o, 1'b0);
    step(32'hFFFF_FFFF, 1'b1, 1'b1);
    step(32'hFFFF_FFFB, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] p;
      p = (i % 4 == 0) ? 32'hFFFF_FFFF - $urandom_range(7, 0) : $urandom;
      step(p, $urandom_range(9, 0) < 7, $urandom_range(9, 0) != 0);
    end
    step(32'h8000_0001, 1'b1, 1'b1);
    step(32'hDEAD_BEE3, 1'b1, 1'b0);
    chk32("rst_comb", pc_four_o, 32'hDEAD_BEE7);
    chk32("rst_q", pc_four_q_o, 32'h0);
    step(32'hFFFF_FFFE, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step($urandom, 1'b0, 1'b1);
    chk32("hold_q", pc_four_q_o, 32'h2);
    chk1("hold_wrap", wrap_q_o, 1'b1);
    chk1("hold_mis", misalign_q_o, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
